// File: rtl/paddle_ctrl_pkg.sv
// Shared Pong definitions: coordinate width, default display/bar geometry
// and the paddle controller state encoding.
package paddle_ctrl_pkg;

    localparam int COORD_W        = 12;
    localparam int DEF_D_HEIGHT   = 470;
    localparam int DEF_BAR_LENGTH = 180;
    localparam int DEF_SPEED      = 4;

    typedef enum logic [1:0] {
        ST_MANUAL   = 2'd0,
        ST_AI_WAIT  = 2'd1,
        ST_AI_TRACK = 2'd2
    } paddle_state_e;

endpackage

// File: rtl/paddle_ctrl_debounce.sv
// Single-button debouncer: a raw level must differ from the accepted level
// for DEBOUNCE+1 consecutive clocks before the accepted level flips.
module debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (raw_i == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE)) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position generator: debounced manual control or delayed autonomous
// ball tracking, producing a clamped, registered bar-top coordinate.
module paddle_ctrl
    import paddle_ctrl_pkg::*;
#(
    parameter int SIDE       = 0,
    parameter int BAR_LENGTH = DEF_BAR_LENGTH,
    parameter int D_HEIGHT   = DEF_D_HEIGHT,
    parameter int SPEED      = DEF_SPEED,
    parameter int DEBOUNCE   = 16,
    parameter int DEADBAND   = 8,
    parameter int AI_DELAY   = 2
) (
    input  logic               in_clock,
    input  logic               in_reset_n,
    input  logic               in_ani_stb,
    input  logic               in_animate,
    input  logic               in_up,
    input  logic               in_down,
    input  logic               in_ai_mode,
    input  logic [COORD_W-1:0] in_ball_x1,
    input  logic [COORD_W-1:0] in_ball_y1,
    input  logic [COORD_W-1:0] in_ball_y2,
    output logic [COORD_W-1:0] out_bar_top,
    output logic               out_at_top,
    output logic               out_at_bottom,
    output logic [1:0]         out_dbg_state
);

    localparam int MAX_TOP    = D_HEIGHT - BAR_LENGTH;
    localparam int CENTRE_TOP = MAX_TOP / 2;
    localparam int HALF       = BAR_LENGTH / 2;
    localparam int DLY_W      = (AI_DELAY < 1) ? 1 : $clog2(AI_DELAY + 1);

    localparam logic [COORD_W:0] MAX_TOP_W  = (COORD_W+1)'(MAX_TOP);
    localparam logic [COORD_W:0] SPEED_W    = (COORD_W+1)'(SPEED);
    localparam logic [COORD_W:0] HALF_W     = (COORD_W+1)'(HALF);
    localparam logic [COORD_W:0] DEADBAND_W = (COORD_W+1)'(DEADBAND);
    localparam logic [COORD_W:0] REST_W     = (COORD_W+1)'(CENTRE_TOP + HALF);

    paddle_state_e      state_q, state_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [COORD_W-1:0] prev_x1_q, prev_x1_d;
    logic               appr_q, appr_d;
    logic [COORD_W-1:0] top_q, top_d;
    logic               at_top_q, at_top_d;
    logic               at_bot_q, at_bot_d;

    logic               up_lvl, down_lvl;
    logic               frame;
    logic               approach;
    logic               appr_rise;
    logic [COORD_W:0]   ysum_w, target_w, centre_w, top_w;
    logic               mv_up, mv_dn;

    debounce #(.DEBOUNCE(DEBOUNCE)) u_db_up (
        .clk_i   (in_clock),
        .rst_ni  (in_reset_n),
        .raw_i   (in_up),
        .level_o (up_lvl)
    );

    debounce #(.DEBOUNCE(DEBOUNCE)) u_db_down (
        .clk_i   (in_clock),
        .rst_ni  (in_reset_n),
        .raw_i   (in_down),
        .level_o (down_lvl)
    );

    assign frame     = in_animate & in_ani_stb;
    assign approach  = (SIDE == 0) ? (in_ball_x1 < prev_x1_q) : (in_ball_x1 > prev_x1_q);
    assign appr_rise = approach & ~appr_q;

    // Mode FSM plus frame-sampled ball history; everything advances on frames only.
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        prev_x1_d = prev_x1_q;
        appr_d    = appr_q;
        if (frame) begin
            prev_x1_d = in_ball_x1;
            appr_d    = approach;
            if (!in_ai_mode) begin
                state_d = ST_MANUAL;
            end else begin
                case (state_q)
                    ST_MANUAL: begin
                        state_d = ST_AI_WAIT;
                        dly_d   = DLY_W'(AI_DELAY);
                    end
                    ST_AI_WAIT: begin
                        if (dly_q == '0) state_d = ST_AI_TRACK;
                        else             dly_d   = dly_q - 1'b1;
                    end
                    ST_AI_TRACK: begin
                        if (appr_rise) begin
                            state_d = ST_AI_WAIT;
                            dly_d   = DLY_W'(AI_DELAY);
                        end
                    end
                    default: state_d = ST_MANUAL;
                endcase
            end
        end
    end

    // Movement follows the rule of the state being entered this frame.
    always_comb begin
        ysum_w   = {1'b0, in_ball_y1} + {1'b0, in_ball_y2};
        target_w = approach ? (ysum_w >> 1) : REST_W;
        centre_w = {1'b0, top_q} + HALF_W;
        top_w    = {1'b0, top_q};
        mv_up    = 1'b0;
        mv_dn    = 1'b0;
        if (frame) begin
            case (state_d)
                ST_MANUAL: begin
                    mv_up = up_lvl & ~down_lvl;
                    mv_dn = down_lvl & ~up_lvl;
                end
                ST_AI_TRACK: begin
                    mv_up = (target_w + DEADBAND_W) < centre_w;
                    mv_dn = target_w > (centre_w + DEADBAND_W);
                end
                default: begin
                    mv_up = 1'b0;
                    mv_dn = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        top_d = top_q;
        if (mv_up) begin
            top_d = (top_w < SPEED_W) ? '0 : (top_q - COORD_W'(SPEED));
        end else if (mv_dn) begin
            top_d = ((top_w + SPEED_W) > MAX_TOP_W) ? COORD_W'(MAX_TOP)
                                                    : (top_q + COORD_W'(SPEED));
        end
        at_top_d = (top_d == '0);
        at_bot_d = (top_d == COORD_W'(MAX_TOP));
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            state_q   <= ST_MANUAL;
            dly_q     <= '0;
            prev_x1_q <= '0;
            appr_q    <= 1'b0;
            top_q     <= COORD_W'(CENTRE_TOP);
            at_top_q  <= 1'b0;
            at_bot_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            prev_x1_q <= prev_x1_d;
            appr_q    <= appr_d;
            top_q     <= top_d;
            at_top_q  <= at_top_d;
            at_bot_q  <= at_bot_d;
        end
    end

    assign out_bar_top   = top_q;
    assign out_at_top    = at_top_q;
    assign out_at_bottom = at_bot_q;
    assign out_dbg_state = state_q;

endmodule
